trans_serializer: RTL

Downstream of the transaction validator. Takes each 128-bit validated transaction pulse (`data_i`/`valid_i`, one-cycle strobe, no backpressure) and buffers it in a small FIFO. Emits it as a stream of 32-bit words with a valid/ready handshake toward the host link (UART/PCIe bridge). It absorbs the validator's bursty output and the link's stalls, and flags any transaction lost to overflow.

---
 rtl/trans_pkg.sv | 38 +++
 rtl/trans_fifo.sv | 73 +++++++
 rtl/trans_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/trans_pkg.sv
// trans_pkg: shared constants and types for the transaction serializer.
// Optional checksum word: define TRANS_SER_CHECKSUM_EN.
package trans_pkg;

   // Validated transaction field layout
   localparam int SENDER_MSB      = 127;
   localparam int SENDER_LSB      = 80;
   localparam int RECEIVER_MSB    = 79;
   localparam int RECEIVER_LSB    = 32;
   localparam int AMOUNT_MSB      = 31;
   localparam int AMOUNT_LSB      = 10;
   localparam int BLOCK_START_BIT = 9;

   localparam int TX_W   = 128;
   localparam int WORD_W = 32;

`ifdef TRANS_SER_CHECKSUM_EN
   localparam int WORDS_PER_TX = 5;
`else
   localparam int WORDS_PER_TX = 4;
`endif

   // Bits held by the output shift register
   localparam int SHREG_W = WORDS_PER_TX * WORD_W;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

   // XOR of the four payload words
   function automatic logic [WORD_W-1:0] tx_checksum(
      input logic [TX_W-1:0] d
   );
      return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
   endfunction

endpackage

// File: rtl/trans_fifo.sv
// trans_fifo: synchronous first-word-fall-through FIFO, async active-low reset.
// Ports: clk, rst_n, push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module trans_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A full FIFO still takes a push when a pop frees a slot this cycle
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/trans_serializer.sv
// trans_serializer: buffers 128-bit transactions, emits them MSB-first as
// 32-bit words on a valid/ready stream; sticky overflow flag on drops.
// Ports: clk, rst_n, data_i/valid_i (strobe in), word_o/valid_o/ready_i/last_o
// (stream out), overflow_o, level_o (FIFO occupancy).
// Define TRANS_SER_CHECKSUM_EN to append an XOR checksum word.
module trans_serializer
   import trans_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [TX_W-1:0]             data_i,
   input  logic                        valid_i,
   output logic [WORD_W-1:0]           word_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        last_o,
   output logic                        overflow_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_TX - 1);

   ser_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SHREG_W-1:0] shreg_q, shreg_d;
   logic              ovf_q, ovf_d;

   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [TX_W-1:0]   fifo_data;
   logic              is_last;
   logic [SHREG_W-1:0] load_val;

   trans_fifo #(
      .WIDTH (TX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (valid_i),
      .data_i  (data_i),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (level_o)
   );

`ifdef TRANS_SER_CHECKSUM_EN
   assign load_val = {fifo_data, tx_checksum(fifo_data)};
`else
   assign load_val = fifo_data;
`endif

   assign is_last = (idx_q == LAST_IDX);

   // Outputs come straight from registers, so valid_o never sees ready_i
   assign word_o     = shreg_q[SHREG_W-1 -: WORD_W];
   assign valid_o    = (state_q == SER_SEND);
   assign last_o     = valid_o && is_last;
   assign overflow_o = ovf_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      unique case (state_q)
         SER_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = load_val;
               idx_d   = '0;
               state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            if (ready_i) begin
               if (!is_last) begin
                  idx_d   = idx_q + IDX_W'(1);
                  shreg_d = {shreg_q[SHREG_W-WORD_W-1:0],
                             {WORD_W{1'b0}}};
               end else if (!fifo_empty) begin
                  // Chain the next transaction with no idle bubble
                  pop     = 1'b1;
                  shreg_d = load_val;
                  idx_d   = '0;
               end else begin
                  shreg_d = '0;
                  idx_d   = '0;
                  state_d = SER_IDLE;
               end
            end
         end
         default: begin
            state_d = SER_IDLE;
         end
      endcase
   end

   // Drop only when full and no slot is freed in the same cycle
   assign ovf_d = ovf_q | (valid_i && fifo_full && !pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SER_IDLE;
         idx_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
